if_fetch_ctrl: RTL and testbench

- Instruction-fetch stage directly downstream of the PC stage.
- Takes pc/i_en/excp each cycle and runs one instruction-bus read per PC value.
- Raises a stall request until the read completes, then registers pc, instruction and exception flags into the IF/ID outputs for decode.
- Discards in-flight bus responses that belong to a flushed PC.

---
 rtl/if_fetch_ctrl.sv | 158 +++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch stage: one instruction-bus read per PC, stall request until
// the read completes, IF/ID register for decode, and discard of flushed responses.
module if_fetch_ctrl #(
    parameter int ADDR_W = 32,
    parameter int EXC_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              i_en,
    input  logic [EXC_W-1:0]  excp,
    input  logic              stall,
    input  logic              flush,
    output logic              i_req,
    output logic [ADDR_W-1:0] i_addr,
    input  logic              i_addr_ok,
    input  logic              i_data_ok,
    input  logic [ADDR_W-1:0] i_rdata,
    output logic              stall_req,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] id_inst,
    output logic [EXC_W-1:0]  id_excp
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REQ       = 3'd1,
        S_WAIT      = 3'd2,
        S_HOLD      = 3'd3,
        S_DROP_REQ  = 3'd4,
        S_DROP_WAIT = 3'd5
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] buf_r;
    logic [ADDR_W-1:0] req_addr_r;
    logic              excp_s;
    logic              idle_req_s;
    logic              done_s;
    logic              drop_s;
    logic              req_s;
    logic [ADDR_W-1:0] fetch_inst_s;

    // Bus request, completion and stall decode from the current state.
    always_comb begin
        excp_s       = (excp != {EXC_W{1'b0}});
        idle_req_s   = i_en & ~excp_s & ~flush;
        drop_s       = (state_r == S_DROP_REQ) | (state_r == S_DROP_WAIT);
        req_s        = 1'b0;
        done_s       = 1'b0;
        fetch_inst_s = {ADDR_W{1'b0}};
        case (state_r)
            S_IDLE: begin
                req_s  = idle_req_s;
                done_s = i_en & excp_s;
            end
            S_REQ:       req_s = 1'b1;
            S_WAIT: begin
                done_s       = i_data_ok;
                fetch_inst_s = i_rdata;
            end
            S_HOLD: begin
                done_s       = 1'b1;
                fetch_inst_s = buf_r;
            end
            S_DROP_REQ:  req_s = 1'b1;
            S_DROP_WAIT: req_s = 1'b0;
            default:     req_s = 1'b0;
        endcase
        // Outputs read 0 while reset is held, whatever the PC stage drives.
        i_req     = rst & req_s;
        stall_req = rst & (drop_s | (i_en & ~done_s & ~flush));
        // A request abandoned by a flush keeps its original address until accepted.
        i_addr    = (state_r == S_DROP_REQ) ? req_addr_r : pc;
    end

    // Fetch state machine and the stall-time instruction buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= S_IDLE;
            buf_r      <= {ADDR_W{1'b0}};
            req_addr_r <= {ADDR_W{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (idle_req_s) begin
                        req_addr_r <= pc;
                        state_r    <= i_addr_ok ? S_WAIT : S_REQ;
                    end
                end
                S_REQ: begin
                    if (flush) begin
                        state_r <= i_addr_ok ? S_DROP_WAIT : S_DROP_REQ;
                    end else if (i_addr_ok) begin
                        state_r <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        state_r <= i_data_ok ? S_IDLE : S_DROP_WAIT;
                    end else if (i_data_ok) begin
                        if (stall) begin
                            buf_r   <= i_rdata;
                            state_r <= S_HOLD;
                        end else begin
                            state_r <= S_IDLE;
                        end
                    end
                end
                S_HOLD: begin
                    if (flush || !stall) begin
                        state_r <= S_IDLE;
                    end
                end
                S_DROP_REQ: begin
                    if (i_addr_ok) begin
                        state_r <= S_DROP_WAIT;
                    end
                end
                S_DROP_WAIT: begin
                    if (i_data_ok) begin
                        state_r <= S_IDLE;
                    end
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

    // IF/ID register: flush clears, stall holds, otherwise deliver or bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_valid <= 1'b0;
            id_pc    <= {ADDR_W{1'b0}};
            id_inst  <= {ADDR_W{1'b0}};
            id_excp  <= {EXC_W{1'b0}};
        end else if (flush) begin
            id_valid <= 1'b0;
            id_pc    <= {ADDR_W{1'b0}};
            id_inst  <= {ADDR_W{1'b0}};
            id_excp  <= {EXC_W{1'b0}};
        end else if (stall) begin
            id_valid <= id_valid;
        end else if (done_s) begin
            id_valid <= 1'b1;
            id_pc    <= pc;
            id_inst  <= fetch_inst_s;
            id_excp  <= excp;
        end else begin
            id_valid <= 1'b0;
            id_pc    <= pc;
            id_inst  <= {ADDR_W{1'b0}};
            id_excp  <= {EXC_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Randomised bench for if_fetch_ctrl: PC-stage and bus models drive the DUT,
// a scoreboard queue holds one expected IF/ID delivery per presented PC.
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        i_en;
    logic [7:0]  excp;
    logic        stall;
    logic        flush;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_addr_ok;
    logic        i_data_ok;
    logic [31:0] i_rdata;
    logic        stall_req;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [7:0]  id_excp;

    always #5 clk = ~clk;

    if_fetch_ctrl #(.ADDR_W(32), .EXC_W(8)) dut (
        .clk(clk), .rst(rst), .pc(pc), .i_en(i_en), .excp(excp),
        .stall(stall), .flush(flush), .i_req(i_req), .i_addr(i_addr),
        .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .stall_req(stall_req), .id_valid(id_valid), .id_pc(id_pc),
        .id_inst(id_inst), .id_excp(id_excp)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [7:0]  excp;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          deliv_cnt = 0;
    int          addr_wait_max, data_wait_max, stall_pct, flush_pct, excp_pct;
    int          burst = 0;
    int          age = 0;
    int          dcnt = 0;
    bit          outstanding = 1'b0;
    bit          req_hold = 1'b0;
    bit          drop_active = 1'b0;
    logic [31:0] out_addr = 32'd0;
    logic [31:0] hold_addr = 32'd0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h3C080001;
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Present a new PC with its exception vector and record the expected delivery.
    task automatic set_pc(input logic [31:0] a, input bit allow_excp);
        exp_t e;
        pc   = a;
        excp = (allow_excp && ($urandom_range(0, 99) < excp_pct)) ? 8'($urandom_range(1, 255)) : 8'h00;
        e.pc   = a;
        e.excp = excp;
        e.inst = (excp != 8'h00) ? 32'd0 : mem_word(a);
        sb_q.push_back(e);
        age = 0;
    endtask

    task automatic set_mix(input int aw, input int dw, input int sp, input int fp, input int ep);
        addr_wait_max = aw; data_wait_max = dw; stall_pct = sp; flush_pct = fp; excp_pct = ep;
    endtask

    // One cycle: entered and left at a negedge.
    task automatic step(input int k);
        bit          adv, acc, dat, fl, req_now;
        logic [31:0] addr_now;
        if (burst == 0 && $urandom_range(0, 99) < stall_pct) burst = $urandom_range(1, 5);
        stall = (burst > 0);
        if (burst > 0) burst--;
        fl    = i_en && ($urandom_range(0, 99) < flush_pct);
        flush = fl;
        dat   = outstanding && (dcnt == 0);
        if (outstanding && dcnt > 0) dcnt--;
        i_data_ok = dat;
        i_rdata   = dat ? mem_word(out_addr) : $urandom();
        #1;
        req_now  = i_req;
        addr_now = i_addr;
        if (outstanding) check("one_outstanding", req_now, 1'b0);
        if (req_hold) begin
            check("req_held", req_now, 1'b1);
            check("addr_stable", addr_now, hold_addr);
        end else if (req_now) begin
            check("req_addr", addr_now, pc);
            check("req_no_excp", excp, 8'h00);
        end
        if (drop_active) check("drop_stall_req", stall_req, 1'b1);
        if (k == 1) begin
            check("first_i_req", req_now, 1'b1);
            check("first_i_addr", addr_now, 32'hBFC00000);
            check("first_stall_req", stall_req, 1'b1);
        end
        if (k == 2) check("second_stall_req", stall_req, 1'b0);
        acc = req_now && ($urandom_range(0, addr_wait_max) == 0);
        i_addr_ok = acc;
        adv = i_en && !stall && !stall_req;
        @(posedge clk);
        #2;
        i_addr_ok = 1'b0;
        i_data_ok = 1'b0;
        if (dat) begin
            outstanding = 1'b0;
            drop_active = 1'b0;
        end
        if (acc) begin
            outstanding = 1'b1;
            out_addr    = addr_now;
            dcnt        = $urandom_range(0, data_wait_max);
        end
        req_hold  = req_now && !acc;
        hold_addr = addr_now;
        if (fl) begin
            if (req_hold || outstanding) drop_active = 1'b1;
            if (sb_q.size() > 0) void'(sb_q.pop_back());
            set_pc($urandom(), 1'b1);
        end else if (adv) begin
            check("lost_fetch", sb_q.size(), 0);
            set_pc(pc + 32'd4, 1'b1);
        end else begin
            age++;
            if (age == 200) check("fetch_timeout", age, 0);
        end
        i_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        #3;
        rst  = 1'b0;
        i_en = 1'b1;
        #1;
        check("rst_i_req", i_req, 1'b0);
        check("rst_stall_req", stall_req, 1'b0);
        check("rst_id_valid", id_valid, 1'b0);
        outstanding = 1'b0; req_hold = 1'b0; drop_active = 1'b0; burst = 0;
        stall = 1'b0; flush = 1'b0; i_addr_ok = 1'b0; i_data_ok = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst  = 1'b1;
        i_en = 1'b0;
    endtask

    // Monitor: checks the IF/ID register after every edge against the rules and the scoreboard.
    initial begin
        logic [79:0] prev, cur;
        logic        r_e, st_e, fl_e;
        logic [31:0] pc_e;
        exp_t        e;
        prev = 80'd0;
        forever begin
            @(posedge clk);
            r_e = rst; st_e = stall; fl_e = flush; pc_e = pc;
            #1;
            cur = {7'd0, id_valid, id_pc, id_inst, id_excp};
            if (!r_e) begin
                check("reset_ifid", cur, 80'd0);
            end else if (fl_e) begin
                check("flush_ifid", cur, 80'd0);
            end else if (st_e) begin
                check("stall_hold", cur, prev);
            end else if (id_valid) begin
                if (sb_q.size() == 0) begin
                    check("spurious_deliver", cur, 80'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("deliver", cur, {7'd0, 1'b1, e.pc, e.inst, e.excp});
                    deliv_cnt++;
                end
            end else begin
                check("bubble", cur, {7'd0, 1'b0, pc_e, 32'd0, 8'd0});
            end
            prev = cur;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst = 1'b0; pc = 32'hBFC00000; i_en = 1'b1; excp = 8'h00; stall = 1'b0; flush = 1'b0;
        i_addr_ok = 1'b0; i_data_ok = 1'b0; i_rdata = 32'd0;
        set_mix(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_i_req", i_req, 1'b0);
        check("reset_stall_req", stall_req, 1'b0);
        @(negedge clk);
        rst  = 1'b1;
        i_en = 1'b0;
        set_pc(32'hBFC00000, 1'b0);
        // Zero-wait bus, no stalls: one instruction every two cycles.
        for (int k = 0; k < 41; k++) step(k);
        check("throughput", deliv_cnt, 20);
        set_mix(3, 3, 10, 5, 10);
        for (int k = 0; k < 1500; k++) step(-1);
        found = 1'b0;
        for (int k = 0; k < 500 && !found; k++) begin
            if (outstanding && !drop_active) found = 1'b1;
            else step(-1);
        end
        check("reach_wait", found, 1'b1);
        if (found) do_reset();
        set_mix(2, 4, 30, 10, 20);
        for (int k = 0; k < 800; k++) step(-1);
        set_mix(1, 1, 0, 0, 0);
        for (int k = 0; k < 50; k++) step(-1);
        check("final_pending", sb_q.size(), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
